// File: rtl/rv32i_dma_pkg.sv
// Shared definitions for the rv32i_dma block: FSM encoding, bus size codes,
// and the per-unit address increment.
package rv32i_dma_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned INC_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Bytes moved per unit; the illegal size code yields 0 and is rejected before use.
    function automatic logic [INC_W-1:0] unit_inc(input logic [1:0] sz);
        case (sz)
            SZ_B:    unit_inc = INC_W'(1);
            SZ_H:    unit_inc = INC_W'(2);
            SZ_W:    unit_inc = INC_W'(4);
            default: unit_inc = INC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/rv32i_dma_if.sv
// Memory-bus bundle between the DMA (master) and the arbiter/memory (slave).
interface rv32i_dma_if;

    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_baddr;
    logic [31:0] m_bdi;
    logic [31:0] m_bdo;
    logic        m_bwr;
    logic [1:0]  m_bsz;

    modport master (
        output m_req,
        output m_baddr,
        output m_bdi,
        output m_bwr,
        output m_bsz,
        input  m_gnt,
        input  m_bdo
    );

    modport slave (
        input  m_req,
        input  m_baddr,
        input  m_bdi,
        input  m_bwr,
        input  m_bsz,
        output m_gnt,
        output m_bdo
    );

endinterface

// File: rtl/rv32i_dma_align_chk.sv
// Combinational command validation: size code, address/length alignment,
// and empty-transfer detection. Only the low two address/length bits matter.
module rv32i_dma_align_chk #(
    parameter int unsigned LEN_W = 16
) (
    input  logic [1:0]       sz,
    input  logic [1:0]       src_lo,
    input  logic [1:0]       dst_lo,
    input  logic [LEN_W-1:0] len,
    input  logic             fill,
    output logic             bad,
    output logic             empty
);
    import rv32i_dma_pkg::*;

    // Nonzero low bits below the unit size mean the value is not unit-aligned.
    function automatic logic misaligned(input logic [1:0] s, input logic [1:0] v);
        case (s)
            SZ_H:    misaligned = v[0];
            SZ_W:    misaligned = |v;
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Fill mode uses src as a data pattern, so its alignment is irrelevant.
    always_comb begin
        bad   = 1'b0;
        empty = 1'b0;
        if (sz == SZ_X) begin
            bad = 1'b1;
        end else begin
            bad = (!fill && misaligned(sz, src_lo))
                | misaligned(sz, dst_lo)
                | misaligned(sz, len[1:0]);
        end
        empty = (len == '0);
    end

endmodule

// File: rtl/rv32i_dma.sv
// Single-channel memory-to-memory DMA for an RV32I system bus.
// Copies len bytes from src to dst in ascending order, one unit (byte, half,
// word) per RD/WR pair. Optional fill mode is enabled by defining
// RV32I_DMA_FILL_EN: with fill=1 the low sz bytes of src are written as a
// pattern to every unit at dst and the read phase is skipped.
module rv32i_dma #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       sz,
    input  logic             fill,
    output logic             busy,
    output logic             done,
    output logic             err,
    rv32i_dma_if.master      bus
);
    import rv32i_dma_pkg::*;

    state_t             state;
    logic [ADDR_W-1:0]  src_ptr;
    logic [ADDR_W-1:0]  dst_ptr;
    logic [LEN_W-1:0]   rem;
    logic [1:0]         sz_q;
    logic [DATA_W-1:0]  data_q;
    logic [ADDR_W-1:0]  baddr_q;
    logic [1:0]         bsz_q;
    logic               req_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               fill_q;

    logic               chk_bad;
    logic               chk_empty;
    logic [INC_W-1:0]   inc;
    logic [ADDR_W-1:0]  src_nxt;
    logic [ADDR_W-1:0]  dst_nxt;
    logic               last_unit;

`ifndef RV32I_DMA_FILL_EN
    logic fill_unused;
    assign fill_unused = fill;
    assign fill_q      = 1'b0;
`endif

    assign inc       = unit_inc(sz_q);
    assign src_nxt   = src_ptr + ADDR_W'(inc);
    assign dst_nxt   = dst_ptr + ADDR_W'(inc);
    assign last_unit = (rem == LEN_W'(inc));

    rv32i_dma_align_chk #(
        .LEN_W (LEN_W)
    ) u_chk (
        .sz     (sz_q),
        .src_lo (src_ptr[1:0]),
        .dst_lo (dst_ptr[1:0]),
        .len    (rem),
        .fill   (fill_q),
        .bad    (chk_bad),
        .empty  (chk_empty)
    );

    // Transfer sequencer; bus address/size/data are registered one cycle ahead of use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            rem     <= '0;
            sz_q    <= '0;
            data_q  <= '0;
            baddr_q <= '0;
            bsz_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RV32I_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        rem     <= len;
                        sz_q    <= sz;
`ifdef RV32I_DMA_FILL_EN
                        fill_q  <= fill;
`endif
                        busy_q  <= 1'b1;
                        state   <= CHK;
                    end
                end
                CHK: begin
                    if (chk_bad || chk_empty) begin
                        done_q <= 1'b1;
                        err_q  <= chk_bad;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        req_q <= 1'b1;
                        bsz_q <= sz_q;
                        if (fill_q) begin
                            data_q  <= src_ptr;
                            baddr_q <= dst_ptr;
                            state   <= WR;
                        end else begin
                            baddr_q <= src_ptr;
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    if (bus.m_gnt) begin
                        data_q  <= bus.m_bdo;
                        baddr_q <= dst_ptr;
                        state   <= WR;
                    end
                end
                WR: begin
                    if (bus.m_gnt) begin
                        src_ptr <= src_nxt;
                        dst_ptr <= dst_nxt;
                        rem     <= rem - LEN_W'(inc);
                        if (last_unit) begin
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            baddr_q <= '0;
                            bsz_q   <= '0;
                            state   <= DONE;
                        end else if (fill_q) begin
                            baddr_q <= dst_nxt;
                        end else begin
                            baddr_q <= src_nxt;
                            state   <= RD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign bus.m_req   = req_q;
    assign bus.m_baddr = baddr_q;
    assign bus.m_bdi   = data_q;
    assign bus.m_bsz   = bsz_q;
    // Write strobe only while granted; a reset edge aborts the write in flight.
    assign bus.m_bwr   = (state == WR) && bus.m_gnt && !rst;

endmodule

// File: tb/tb_rv32i_dma.sv
// Directed bench for rv32i_dma: table of transfer commands with hand-computed
// timing/status, a byte-array memory with a reference copy, and hand-written
// sequences for mid-transfer reset and start-while-busy.
module tb_rv32i_dma;
    import rv32i_dma_pkg::*;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MEM_N     = 4096;
    localparam int          CYC_LIMIT = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [1:0]       sz;
    logic             fill;
    logic             busy;
    logic             done;
    logic             err;

    rv32i_dma_if bus();

    rv32i_dma #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .sz    (sz),
        .fill  (fill),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [LEN_W-1:0] len;
        logic [1:0]       sz;
        logic             fill;
        int               drop_at;
        logic             exp_err;
        int               exp_cyc;
        int               exp_bus;
        int               exp_wr;
    } vec_t;

    logic [7:0] mem     [MEM_N];
    logic [7:0] exp_mem [MEM_N];
    logic       mem_load = 1'b0;
    int         wr_cnt = 0;
    int         bad_wr_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    vec_t       vecs [$];

    wire [11:0] wa = bus.m_baddr[11:0];

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Bus slave memory: low unit bytes of write data land at consecutive addresses.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= init_byte(i);
        end else if (bus.m_bwr) begin
            wr_cnt <= wr_cnt + 1;
            if (!bus.m_gnt) bad_wr_cnt <= bad_wr_cnt + 1;
            mem[wa] <= bus.m_bdi[7:0];
            if (bus.m_bsz != SZ_B) mem[wa + 12'd1] <= bus.m_bdi[15:8];
            if (bus.m_bsz == SZ_W) begin
                mem[wa + 12'd2] <= bus.m_bdi[23:16];
                mem[wa + 12'd3] <= bus.m_bdi[31:24];
            end
        end
    end

    // Combinational read data, little-endian from the addressed byte upward.
    always_comb begin
        bus.m_bdo = {mem[wa + 12'd3], mem[wa + 12'd2], mem[wa + 12'd1], mem[wa]};
    end

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic cmp_mem(input string name);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < MEM_N; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        if (first >= 0)
            $display("  first differing byte at 0x%0h: got 0x%0h want 0x%0h",
                     first, mem[first], exp_mem[first]);
        check({name, "_mem_bad_bytes"}, nbad, 0);
    endtask

    // Reference effect of a completed command on memory.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) exp_mem[12'(d + i)] = exp_mem[12'(s + i)];
    endtask

    task automatic model_fill(input logic [31:0] pat, input logic [31:0] d, input int n,
                              input int unit);
        logic [31:0] sh;
        for (int i = 0; i < n; i++) begin
            sh = pat >> (8 * (i % unit));
            exp_mem[12'(d + i)] = sh[7:0];
        end
    endtask

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input int l,
                                input logic [1:0] z, input logic f, input int drop,
                                input logic e, input int cyc, input int nb, input int nw);
        vec_t v;
        v.src = s; v.dst = d; v.len = LEN_W'(l); v.sz = z; v.fill = f;
        v.drop_at = drop; v.exp_err = e; v.exp_cyc = cyc; v.exp_bus = nb; v.exp_wr = nw;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int bus_cnt;
        int wr0;
        bit seen;
        string tag;
        tag     = $sformatf("v%0d", idx);
        bus_cnt = 0;
        seen    = 0;
        wr0     = wr_cnt;
        @(negedge clk);
        src = v.src; dst = v.dst; len = v.len; sz = v.sz; fill = v.fill; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_after_start"}, busy, 1);
        while (cyc <= CYC_LIMIT) begin
            bus.m_gnt = !(v.drop_at != 0 && cyc >= v.drop_at && cyc < v.drop_at + 5);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
            if (bus.m_req && bus.m_gnt) bus_cnt++;
            @(negedge clk);
            cyc++;
        end
        bus.m_gnt = 1'b1;
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_cycles"}, cyc, v.exp_cyc);
            check({tag, "_err"}, err, v.exp_err);
            check({tag, "_busy_at_done"}, busy, 0);
            check({tag, "_req_at_done"}, bus.m_req, 0);
            check({tag, "_bus_cycles"}, bus_cnt, v.exp_bus);
            check({tag, "_writes"}, wr_cnt - wr0, v.exp_wr);
            @(negedge clk);
            check({tag, "_done_pulse_len"}, done, 0);
        end
        if (!v.exp_err) begin
`ifdef RV32I_DMA_FILL_EN
            if (v.fill) model_fill(v.src, v.dst, int'(v.len), 1 << v.sz);
            else        model_copy(v.src, v.dst, int'(v.len));
`else
            model_copy(v.src, v.dst, int'(v.len));
`endif
        end
        cmp_mem(tag);
    endtask

    initial begin
        int wr0;
        bit found;
        bit seen;
        bit busy_rose;
        int cyc;

        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; sz = '0; fill = 1'b0;
        bus.m_gnt = 1'b1;
        for (int i = 0; i < MEM_N; i++) exp_mem[i] = init_byte(i);

        // Command table: src, dst, len, sz, fill, gnt-drop cycle, err, cycles, bus cycles, writes.
        vecs.push_back(mk(32'h100, 32'h200, 16, SZ_W, 0, 0, 0, 10, 8, 4));
        vecs.push_back(mk(32'h101, 32'h303, 3,  SZ_B, 0, 0, 0, 8,  6, 3));
        vecs.push_back(mk(32'h122, 32'h2F0, 6,  SZ_H, 0, 0, 0, 8,  6, 3));
        vecs.push_back(mk(32'h102, 32'h200, 16, SZ_W, 0, 0, 1, 2,  0, 0));
        vecs.push_back(mk(32'h100, 32'h200, 0,  SZ_W, 0, 0, 0, 2,  0, 0));
        vecs.push_back(mk(32'h100, 32'h200, 4,  SZ_X, 0, 0, 1, 2,  0, 0));
        vecs.push_back(mk(32'h100, 32'h200, 3,  SZ_H, 0, 0, 1, 2,  0, 0));
        vecs.push_back(mk(32'h100, 32'h202, 4,  SZ_W, 0, 0, 1, 2,  0, 0));
        vecs.push_back(mk(32'h140, 32'h240, 16, SZ_W, 0, 4, 0, 15, 8, 4));
        vecs.push_back(mk(32'hFFFF_FFF8, 32'h800, 16, SZ_W, 0, 0, 0, 10, 8, 4));
`ifdef RV32I_DMA_FILL_EN
        vecs.push_back(mk(32'h0A5, 32'h400, 4, SZ_B, 1, 0, 0, 6, 4, 4));
        vecs.push_back(mk(32'hDEAD_BEEF, 32'h420, 8, SZ_W, 1, 0, 0, 4, 2, 2));
`else
        vecs.push_back(mk(32'h110, 32'h410, 4, SZ_H, 1, 0, 0, 6, 4, 2));
        vecs.push_back(mk(32'h103, 32'h420, 8, SZ_W, 1, 0, 1, 2, 0, 0));
`endif

        mem_load = 1'b1;
        @(posedge clk);
        #1 mem_load = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_req", bus.m_req, 0);
        check("reset_bwr", bus.m_bwr, 0);
        check("reset_baddr", bus.m_baddr, 0);
        check("reset_bdi", bus.m_bdi, 0);
        check("reset_bsz", bus.m_bsz, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset during the third WR of a 16-byte word copy.
        wr0 = wr_cnt;
        found = 0;
        @(negedge clk);
        src = 32'h180; dst = 32'h500; len = LEN_W'(16); sz = SZ_W; fill = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.m_bwr && (wr_cnt - wr0) == 2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_third_wr_seen", found, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_err", err, 0);
        check("rstmid_req", bus.m_req, 0);
        check("rstmid_bwr", bus.m_bwr, 0);
        check("rstmid_baddr", bus.m_baddr, 0);
        check("rstmid_bdi", bus.m_bdi, 0);
        check("rstmid_bsz", bus.m_bsz, 0);
        check("rstmid_writes", wr_cnt - wr0, 2);
        rst = 1'b0;
        model_copy(32'h180, 32'h500, 8);
        cmp_mem("rstmid");

        // A second start while busy must be ignored.
        wr0 = wr_cnt;
        seen = 0;
        busy_rose = 0;
        @(negedge clk);
        src = 32'h1C0; dst = 32'h600; len = LEN_W'(8); sz = SZ_W; fill = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 40) begin
            if (cyc == 3) begin
                src = 32'h1D0; dst = 32'h700; len = LEN_W'(4); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("busystart_done_seen", seen, 1);
        check("busystart_cycles", cyc, 6);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy) busy_rose = 1;
        end
        check("busystart_no_restart", busy_rose, 0);
        check("busystart_writes", wr_cnt - wr0, 2);
        model_copy(32'h1C0, 32'h600, 8);
        cmp_mem("busystart");

        check("bwr_without_gnt", bad_wr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_dma.md
RV32I_DMA -- requirements
Module: rv32i_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the byte-length field and remaining-byte counter.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-005 SHALL have port src  input  32  source byte address.
REQ-006 SHALL have port dst  input  32  destination byte address.
REQ-007 SHALL have port len  input  LEN_W  transfer length in bytes.
REQ-008 SHALL have port sz  input  2  unit size: 00 byte, 01 half, 10 word.
REQ-009 SHALL have port fill  input  1  fill-mode select, sampled with start (only with the REQ-029 macro).
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle error pulse, coincident with done.
REQ-013 SHALL have port m_req  output  1  bus request to the arbiter.
REQ-014 SHALL have port m_gnt  input  1  bus grant; the DMA drives the bus only while high.
REQ-015 SHALL have port m_baddr, m_bdi, m_bdo, m_bwr, m_bsz  out/out/in/out/out  32/32/32/1/2  memory bus: byte address, write data, combinational read data, write enable, size.

Function
REQ-016 SHALL use FSM states IDLE, CHK, RD, WR, DONE.
REQ-017 SHALL, in IDLE on start=1, latch src, dst, len, sz and fill, and go to CHK.
REQ-018 SHALL, in CHK, go to DONE with err=1 when sz=11, src or dst is misaligned to sz, or len is not a multiple of the unit; go to DONE with err=0 when len=0; otherwise assert m_req and go to RD (or to WR in fill mode).
REQ-019 SHALL, in RD with m_gnt=1, drive m_baddr=src pointer, m_bsz=sz and m_bwr=0, capture m_bdo into the data register at the clock edge, and go to WR.
REQ-020 SHALL, in WR with m_gnt=1, drive m_baddr=dst pointer, m_bdi=data register, m_bsz=sz and m_bwr=1; then advance both pointers by the unit size (1/2/4) and decrement the remaining count by it.
REQ-021 SHALL, after WR, go to DONE when the remaining count reaches 0; otherwise go to RD (or WR in fill mode).
REQ-022 SHALL, in RD or WR with m_gnt=0, hold state, pointers and count, force m_bwr=0, and not capture data.
REQ-023 SHALL make throughput 2 cycles per unit under continuous grant: a word copy of 16 bytes takes 8 bus cycles.
REQ-024 SHALL, in DONE, pulse done for one cycle, deassert m_req and busy, and return to IDLE.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL copy in ascending address order only; overlapping regions are not handled.
REQ-027 SHALL compute pointer arithmetic modulo 2^32, wrapping without error.

Reset
REQ-028 SHALL, with rst=1 at any clock edge including mid-transfer, enter IDLE and clear busy, done, err, m_req, m_bwr, m_baddr, m_bdi, m_bsz and the data register to 0; memory already written is left as is.

Configuration
REQ-029 SHALL, with macro RV32I_DMA_FILL_EN defined, treat fill=1 as fill mode: skip RD, write the low sz bytes of src (used as pattern) to every unit at dst, and skip the src alignment check.
REQ-030 SHALL, without RV32I_DMA_FILL_EN, ignore fill and always copy.

Structure
REQ-031 SHALL place the state encoding, size codes (SZ_B=00, SZ_H=01, SZ_W=10) and the unit-increment function in shared package rv32i_dma_pkg.
REQ-032 SHALL place the alignment and length check in sub-module rv32i_dma_align_chk, purely combinational.

Verification
REQ-033 SHALL cover: word copy, src=0x100, dst=0x200, len=16, m_gnt tied 1 -> 8 bus cycles, memory 0x200..0x20F equals 0x100..0x10F, done pulse, err=0.
REQ-034 SHALL cover: byte copy, src=0x101, dst=0x303, len=3 -> only bytes 0x303..0x305 change, neighbouring lanes intact.
REQ-035 SHALL cover: sz=10, src=0x102 -> done and err in the same cycle, no m_bwr ever asserted; and len=0 -> done with err=0, no bus access.
REQ-036 SHALL cover: m_gnt dropped for 5 cycles mid-transfer -> no writes while low, final contents correct, total time +5 cycles.
REQ-037 SHALL cover: rst asserted during the third WR of a 16-byte word copy -> next cycle all outputs 0, exactly 2 words written; start while busy -> ignored.
REQ-038 SHALL cover, with RV32I_DMA_FILL_EN: fill=1, src=0xA5, sz=00, dst=0x400, len=4 -> 0x400..0x403 all 0xA5 in 4 bus cycles.
